// File: rtl/cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_if
// Brief    : CPU, valid/tag/data array and main-memory signals of cache_ctrl.
// Revision : 1.0
// ============================================================================
interface cache_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        flush;

  logic [10:0] v_addr;
  logic        v_rdata;
  logic        v_wdata;
  logic        v_we;
  logic        v_clr;

  logic [10:0] t_addr;
  logic [18:0] t_wdata;
  logic [18:0] t_rdata;
  logic        t_we;

  logic [10:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_we;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  // Controller side.
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
    input  v_rdata, t_rdata, d_rdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ack,
    output v_addr, v_wdata, v_we, v_clr,
    output t_addr, t_wdata, t_we,
    output d_addr, d_wdata, d_we,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output hit_cnt, miss_cnt
  );

  // CPU, arrays and memory side.
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
    output v_rdata, t_rdata, d_rdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ack,
    input  v_addr, v_wdata, v_we, v_clr,
    input  t_addr, t_wdata, t_we,
    input  d_addr, d_wdata, d_we,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  hit_cnt, miss_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl
// Brief    : Direct-mapped, write-through/no-allocate cache controller.
// Revision : 1.0
// ============================================================================
module cache_ctrl (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    REFILL  = 3'd2,
    UPDATE  = 3'd3,
    WRITE   = 3'd4,
    FLUSH   = 3'd5
  } state_t;

  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  state_t      r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_cpu_ack;
  logic [31:0] r_cpu_rdata;
  logic        r_v_we;
  logic        r_t_we;
  logic        r_d_we;
  logic [31:0] r_d_wdata;
  logic        r_v_clr;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  logic [18:0] w_tag;
  logic [10:0] w_index;
  logic        w_hit;
  logic        w_unused;

  assign w_tag    = r_addr[31:13];
  assign w_index  = r_addr[12:2];
  assign w_hit    = bus.v_rdata & (bus.t_rdata == w_tag);
  assign w_unused = &{1'b0, r_addr[1:0]};

  assign bus.v_addr    = w_index;
  assign bus.t_addr    = w_index;
  assign bus.d_addr    = w_index;
  assign bus.v_wdata   = 1'b1;
  assign bus.v_we      = r_v_we;
  // Reset clears the valid array on the first clock edge it sees.
  assign bus.v_clr     = r_v_clr | ~rst;
  assign bus.t_wdata   = w_tag;
  assign bus.t_we      = r_t_we;
  assign bus.d_wdata   = r_d_wdata;
  assign bus.d_we      = r_d_we;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.hit_cnt   = r_hit_cnt;
  assign bus.miss_cnt  = r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= 32'd0;
      r_v_we      <= 1'b0;
      r_t_we      <= 1'b0;
      r_d_we      <= 1'b0;
      r_d_wdata   <= 32'd0;
      r_v_clr     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_hit_cnt   <= 16'd0;
      r_miss_cnt  <= 16'd0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_v_we    <= 1'b0;
      r_t_we    <= 1'b0;
      r_d_we    <= 1'b0;
      r_v_clr   <= 1'b0;
      case (r_state)
        IDLE: begin
          // The request is still high during its own ack cycle; skip it.
          if (bus.flush) begin
            r_v_clr <= 1'b1;
            r_state <= FLUSH;
          end else if (bus.cpu_req && !r_cpu_ack) begin
            r_we    <= bus.cpu_we;
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_wdata;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_hit) begin
            if (r_hit_cnt != c_cnt_max) r_hit_cnt <= r_hit_cnt + 16'd1;
          end else begin
            if (r_miss_cnt != c_cnt_max) r_miss_cnt <= r_miss_cnt + 16'd1;
          end
          if (!r_we) begin
            if (w_hit) begin
              r_cpu_ack   <= 1'b1;
              r_cpu_rdata <= bus.d_rdata;
              r_state     <= IDLE;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {r_addr[31:2], 2'b00};
              r_state    <= REFILL;
            end
          end else begin
            if (w_hit) begin
              r_d_we    <= 1'b1;
              r_d_wdata <= r_wdata;
            end
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {r_addr[31:2], 2'b00};
            r_mem_wdata <= r_wdata;
            r_state     <= WRITE;
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            r_mem_req   <= 1'b0;
            r_v_we      <= 1'b1;
            r_t_we      <= 1'b1;
            r_d_we      <= 1'b1;
            r_d_wdata   <= bus.mem_rdata;
            r_cpu_ack   <= 1'b1;
            r_cpu_rdata <= bus.mem_rdata;
            r_state     <= UPDATE;
          end
        end
        UPDATE: r_state <= IDLE;
        WRITE: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_cpu_ack <= 1'b1;
            r_state   <= IDLE;
          end
        end
        FLUSH:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ctrl
// Brief    : Self-checking bench for cache_ctrl with array and memory models.
// Revision : 1.0
// ============================================================================
module tb_cache_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_ctrl_if bus();
  cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // Valid/tag/data storage seen by the controller.
  bit          v_arr [2048];
  logic [18:0] t_arr [2048];
  logic [31:0] d_arr [2048];
  assign bus.v_rdata = (bus.v_we | bus.v_clr) ? 1'b0 : v_arr[bus.v_addr];
  assign bus.t_rdata = t_arr[bus.t_addr];
  assign bus.d_rdata = d_arr[bus.d_addr];
  always @(posedge clk) begin
    if (bus.v_clr) begin
      for (int i = 0; i < 2048; i++) v_arr[i] <= 1'b0;
    end else if (bus.v_we) begin
      v_arr[bus.v_addr] <= bus.v_wdata;
    end
    if (bus.t_we) t_arr[bus.t_addr] <= bus.t_wdata;
    if (bus.d_we) d_arr[bus.d_addr] <= bus.d_wdata;
  end

  // Reference: what the cache should hold, plus main memory contents.
  bit          ref_valid [2048];
  logic [18:0] ref_tag   [2048];
  logic [31:0] ref_data  [2048];
  logic [31:0] mem_model [bit [29:0]];
  int unsigned exp_hits, exp_misses;
  int tests, fails;

  function automatic logic [31:0] mem_read(input logic [29:0] w);
    if (mem_model.exists(w)) return mem_model[w];
    return {w, 2'b11} ^ 32'hA5A5_0F0F;
  endfunction

  function automatic void ref_invalidate();
    for (int i = 0; i < 2048; i++) ref_valid[i] = 1'b0;
  endfunction

  task automatic cpu_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int lat, input bit flush_mid,
                            output logic [31:0] rdata, output bit used_mem, output int ack_cyc);
    logic [10:0] idx;
    logic [18:0] tag;
    bit          exp_hit, acked, done, saw_dwe, saw_vwe, saw_twe, saw_vclr, got;
    logic [31:0] exp_data, dwe_data;
    int          mcnt;
    idx = addr[12:2];
    tag = addr[31:13];
    exp_hit  = ref_valid[idx] && (ref_tag[idx] == tag);
    exp_data = exp_hit ? ref_data[idx] : mem_read(addr[31:2]);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    used_mem = 0; ack_cyc = 0; rdata = 32'd0; mcnt = 0; acked = 0; done = 0;
    saw_dwe = 0; saw_vwe = 0; saw_twe = 0; saw_vclr = 0; dwe_data = 32'd0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(posedge clk); #1;
      if (bus.mem_ack) bus.mem_ack = 1'b0;
      if (flush_mid && c == 1) bus.flush = 1'b1;
      if (bus.v_clr) saw_vclr = 1;
      if (bus.d_we) begin saw_dwe = 1; dwe_data = bus.d_wdata; end
      if (bus.v_we) saw_vwe = 1;
      if (bus.t_we) saw_twe = 1;
      if (!acked && (used_mem || bus.mem_req)) begin
        if (used_mem) begin
          tests++;
          if (bus.mem_req !== 1'b1) begin
            fails++; $display("FAIL mem_req_held: mem_req=%b required 1", bus.mem_req);
          end
        end else begin
          used_mem = 1;
          tests++;
          if (bus.mem_we !== we || bus.mem_addr !== {addr[31:2], 2'b00} ||
              (we && bus.mem_wdata !== wdata)) begin
            fails++;
            $display("FAIL mem_cmd: we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, we, {addr[31:2], 2'b00}, wdata);
          end
        end
        if (bus.mem_req) begin
          mcnt++;
          if (mcnt >= lat) begin
            bus.mem_ack = 1'b1; acked = 1;
            if (we) mem_model[addr[31:2]] = wdata;
            else bus.mem_rdata = mem_read(addr[31:2]);
          end
        end
      end
      if (bus.cpu_ack) begin
        done = 1; ack_cyc = c; rdata = bus.cpu_rdata; bus.cpu_req = 1'b0;
        if (!we && !exp_hit) begin
          tests++;
          if (!(bus.v_we && bus.t_we && bus.d_we && bus.v_wdata) ||
              bus.t_wdata !== tag || bus.d_wdata !== exp_data) begin
            fails++;
            $display("FAIL update_write: v/t/d_we=%b%b%b tag=%h data=%h required 111 tag=%h data=%h",
                     bus.v_we, bus.t_we, bus.d_we, bus.t_wdata, bus.d_wdata, tag, exp_data);
          end
        end
      end
    end
    tests++;
    if (!done) begin
      fails++; $display("FAIL ack_timeout: no cpu_ack for addr %h we=%b", addr, we);
      bus.cpu_req = 1'b0; bus.mem_ack = 1'b0;
    end else begin
      tests++;
      if (used_mem !== (!exp_hit || we)) begin
        fails++; $display("FAIL mem_usage: used=%b required %b (addr %h we=%b)", used_mem, !exp_hit || we, addr, we);
      end
      if (!we) begin
        tests++;
        if (rdata !== exp_data) begin
          fails++; $display("FAIL load_data: got %h required %h (addr %h)", rdata, exp_data, addr);
        end
      end
      if (!we && exp_hit) begin
        tests++;
        if (ack_cyc != 2 || saw_dwe || saw_vwe || saw_twe) begin
          fails++; $display("FAIL hit_path: ack after %0d cycles writes=%b%b%b required 2 and 000",
                            ack_cyc, saw_vwe, saw_twe, saw_dwe);
        end
      end
      if (we) begin
        tests++;
        if (saw_dwe !== exp_hit || (exp_hit && dwe_data !== wdata) || saw_vwe || saw_twe) begin
          fails++; $display("FAIL store_arrays: d_we=%b data=%h v_we=%b t_we=%b required d_we=%b data=%h 0 0",
                            saw_dwe, dwe_data, saw_vwe, saw_twe, exp_hit, wdata);
        end
      end
      if (flush_mid) begin
        tests++;
        if (saw_vclr) begin
          fails++; $display("FAIL flush_busy: v_clr=1 during access, required 0");
        end
      end
    end
    if (exp_hit) begin
      if (exp_hits < 65535) exp_hits++;
    end else begin
      if (exp_misses < 65535) exp_misses++;
    end
    if (!we && !exp_hit) begin
      ref_valid[idx] = 1'b1; ref_tag[idx] = tag; ref_data[idx] = exp_data;
    end
    if (we) begin
      mem_model[addr[31:2]] = wdata;
      if (exp_hit) ref_data[idx] = wdata;
    end
    @(posedge clk); #1;
    tests++;
    if (bus.cpu_ack !== 1'b0 || bus.hit_cnt !== 16'(exp_hits) || bus.miss_cnt !== 16'(exp_misses)) begin
      fails++; $display("FAIL ack_and_counters: ack=%b hit=%0d miss=%0d required 0 %0d %0d",
                        bus.cpu_ack, bus.hit_cnt, bus.miss_cnt, exp_hits, exp_misses);
    end
    if (flush_mid) begin
      got = 0;
      for (int c = 0; c < 3 && !got; c++) begin
        if (bus.v_clr) got = 1;
        else begin @(posedge clk); #1; end
      end
      bus.flush = 1'b0;
      tests++;
      if (!got) begin
        fails++; $display("FAIL flush_accept: v_clr=0 after access, required 1");
      end
      ref_invalidate();
      @(posedge clk); #1;
    end
  endtask

  task automatic do_flush();
    bit got;
    got = 0;
    bus.flush = 1'b1;
    for (int c = 0; c < 5 && !got; c++) begin
      @(posedge clk); #1;
      if (bus.v_clr) got = 1;
    end
    bus.flush = 1'b0;
    tests++;
    if (!got) begin
      fails++; $display("FAIL flush_vclr: v_clr=0 required 1");
    end
    @(posedge clk); #1;
    tests++;
    if (bus.v_clr !== 1'b0) begin
      fails++; $display("FAIL vclr_pulse: v_clr=%b required 0", bus.v_clr);
    end
    ref_invalidate();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
    bus.flush = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    #1;
    tests++;
    if (bus.cpu_ack || bus.mem_req || bus.v_we || bus.t_we || bus.d_we) begin
      fails++; $display("FAIL reset_strobes: ack=%b mem_req=%b we=%b%b%b required all 0",
                        bus.cpu_ack, bus.mem_req, bus.v_we, bus.t_we, bus.d_we);
    end
    tests++;
    if (bus.v_clr !== 1'b1) begin
      fails++; $display("FAIL reset_vclr: v_clr=%b required 1", bus.v_clr);
    end
    tests++;
    if (bus.cpu_rdata !== 32'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 ||
        bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_values: rdata=%h maddr=%h mwdata=%h hit=%0d miss=%0d required all 0",
                        bus.cpu_rdata, bus.mem_addr, bus.mem_wdata, bus.hit_cnt, bus.miss_cnt);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.v_clr !== 1'b0) begin
      fails++; $display("FAIL release_vclr: v_clr=%b required 0", bus.v_clr);
    end
    @(posedge clk); #1;
    ref_invalidate();
    exp_hits = 0; exp_misses = 0;
  endtask

  task automatic test_directed();
    logic [31:0] rd;
    bit um;
    int ac;
    mem_model[30'h0000_1004 >> 2] = 32'hDEAD_BEEF;
    mem_model[30'h0000_3004 >> 2] = 32'hCAFE_F00D;
    cpu_access(1'b0, 32'h0000_1004, 32'd0, 3, 1'b0, rd, um, ac);
    tests++;
    if (rd !== 32'hDEAD_BEEF || !um || bus.miss_cnt !== 16'd1) begin
      fails++; $display("FAIL first_miss: rdata=%h mem=%b miss=%0d required deadbeef 1 1", rd, um, bus.miss_cnt);
    end
    cpu_access(1'b0, 32'h0000_1004, 32'd0, 3, 1'b0, rd, um, ac);
    tests++;
    if (rd !== 32'hDEAD_BEEF || um || ac != 2 || bus.hit_cnt !== 16'd1) begin
      fails++; $display("FAIL first_hit: rdata=%h mem=%b lat=%0d hit=%0d required deadbeef 0 2 1",
                        rd, um, ac, bus.hit_cnt);
    end
    cpu_access(1'b0, 32'h0000_3004, 32'd0, 2, 1'b0, rd, um, ac);
    tests++;
    if (rd !== 32'hCAFE_F00D || !um) begin
      fails++; $display("FAIL conflict_miss: rdata=%h mem=%b required cafef00d 1", rd, um);
    end
    cpu_access(1'b0, 32'h0000_1004, 32'd0, 1, 1'b0, rd, um, ac);
    tests++;
    if (!um) begin
      fails++; $display("FAIL evicted_miss: mem=%b required 1", um);
    end
    cpu_access(1'b0, 32'h0000_3004, 32'd0, 1, 1'b0, rd, um, ac);
    cpu_access(1'b1, 32'h0000_3004, 32'h1234_5678, 2, 1'b0, rd, um, ac);
    cpu_access(1'b0, 32'h0000_3004, 32'd0, 1, 1'b0, rd, um, ac);
    tests++;
    if (rd !== 32'h1234_5678 || um) begin
      fails++; $display("FAIL store_hit_readback: rdata=%h mem=%b required 12345678 0", rd, um);
    end
    do_flush();
    cpu_access(1'b0, 32'h0000_3004, 32'd0, 2, 1'b0, rd, um, ac);
    tests++;
    if (!um || rd !== 32'h1234_5678) begin
      fails++; $display("FAIL post_flush: mem=%b rdata=%h required 1 12345678", um, rd);
    end
  endtask

  task automatic test_reset_refill();
    bit got, bad;
    got = 0; bad = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_5008;
    for (int c = 0; c < 6 && !got; c++) begin
      @(posedge clk); #1;
      if (bus.mem_req) got = 1;
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL refill_start: mem_req=0 required 1");
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bus.mem_req !== 1'b0 || bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_abort: mem_req=%b hit=%0d miss=%0d required 0 0 0",
                        bus.mem_req, bus.hit_cnt, bus.miss_cnt);
    end
    bus.cpu_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.cpu_ack || bus.v_we || bus.t_we || bus.d_we || bus.mem_req) bad = 1;
      @(posedge clk); #1;
    end
    tests++;
    if (bad || bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin
      fails++; $display("FAIL late_ack: activity=%b hit=%0d miss=%0d required 0 0 0",
                        bad, bus.hit_cnt, bus.miss_cnt);
    end
    ref_invalidate();
    exp_hits = 0; exp_misses = 0;
  endtask

  task automatic test_random(input int n);
    logic [31:0] rd, addr;
    bit um, we, fm;
    int ac;
    logic [10:0] idx;
    logic [18:0] tag;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0: idx = 11'd0;
        1: idx = 11'd1;
        2: idx = 11'd2;
        default: idx = 11'd2047;
      endcase
      case ($urandom_range(0, 2))
        0: tag = 19'd0;
        1: tag = 19'd1;
        default: tag = 19'h7FFFF;
      endcase
      addr = {tag, idx, 2'($urandom_range(0, 3))};
      we = ($urandom_range(0, 2) == 0);
      fm = ($urandom_range(0, 15) == 0);
      cpu_access(we, addr, $urandom, $urandom_range(1, 4), fm, rd, um, ac);
      if ($urandom_range(0, 19) == 0) do_flush();
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_directed();
    test_reset_refill();
    test_random(250);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire
